pampy_ctrl: RTL and testbench
=============================

# pampy_ctrl

Instruction sequencer for the pamPy stack processor. Fetches 8-bit opcode/8-bit argument pairs from program memory over a req/ack handshake, decodes a CPython-wordcode subset, and drives the stack datapath with one-cycle push/pop/ALU strobes. Tracks stack depth, raising a sticky error on overflow, underflow or an illegal opcode. Owns the PC and feeds the top-level GENERAL_PC_OUT / GENERAL_INSTR_OUT / GENERAL_ARG_OUT observation ports.

## Interface
- STACK_DEPTH, 16: datapath stack entries; SP width = $clog2(STACK_DEPTH+1).
- PC_W, 12: PC width.
- general_clk  in  1  single clock, rising edge.
- general_reset  in  1  asynchronous, active-high reset.
- MEM_REQ  out  1  fetch request, held until MEM_ACK.
- MEM_ADDR  out  PC_W  fetch address (= PC).
- MEM_ACK  in  1  opcode/arg valid this cycle.
- MEM_INSTR_IN  in  8  opcode.
- MEM_ARG_IN  in  8  argument.
- TOP_STACK_IN  in  8  current top of stack (for conditional jump).
- STACK_PUSH  out  1  push strobe.
- STACK_POP_CNT  out  2  entries popped this cycle (0-2).
- STACK_SRC_SEL  out  1  push source: 0 = arg (constant), 1 = ALU result.
- ALU_OP  out  2  0 add, 1 sub (top-1 minus top).
- GENERAL_PC_OUT  out  PC_W  PC of instruction in flight.
- GENERAL_INSTR_OUT, GENERAL_ARG_OUT  out  8  latched opcode/arg.
- SP_OUT  out  SP width  current stack depth.
- HALT_OUT  out  1  in HALT.
- ERR_OUT  out  1  sticky error (valid with HALT_OUT).

## Operation
- States: IDLE -> FETCH -> DECODE -> EXEC -> FETCH; EXEC -> HALT on RETURN_VALUE or error; HALT exits only on reset.
- IDLE: one cycle after reset release; no outputs active.
- FETCH: MEM_REQ=1, MEM_ADDR=PC; on MEM_ACK latch opcode/arg, go DECODE. MEM_ACK outside FETCH ignored.
- DECODE: classify opcode, check SP against requirement; on failure EXEC raises error instead of strobing.
- EXEC: strobes valid exactly this cycle; PC <= PC+2 unless jump taken.
- Opcodes: NOP 0x09: nothing. POP_TOP 0x01: pop 1, needs SP>=1. BINARY_ADD 0x17 / BINARY_SUBTRACT 0x18: pop 2, push ALU, needs SP>=2, SP-=1. LOAD_CONST 0x64: push arg, needs SP<STACK_DEPTH. JUMP_ABSOLUTE 0x71: PC <= zero-extended arg. POP_JUMP_IF_FALSE 0x72: pop 1, needs SP>=1; if TOP_STACK_IN==0 PC <= arg else PC+2. RETURN_VALUE 0x53: needs SP>=1, pop 1, HALT with ERR=0.
- Errors: underflow, overflow, any other opcode -> no strobes, ERR_OUT=1, HALT; PC not advanced (points at faulting instruction).
- PC wraps modulo 2^PC_W.

## Timing
- Reset (async): state IDLE, PC 0, SP 0, latched instr/arg 0, all strobes/MEM_REQ/HALT_OUT/ERR_OUT 0.
- Reset mid-fetch: MEM_REQ drops immediately; pending ACK discarded.
- Instruction latency = FETCH cycles (>=1, until ACK) + DECODE 1 + EXEC 1; zero-wait memory = 3 cycles/instruction.
- MEM_ACK in the first FETCH cycle is accepted.
- SP_OUT, PC update on the clock edge ending EXEC; TOP_STACK_IN sampled in EXEC (pre-pop value).
- All outputs registered or decoded from registered state; no combinational input-to-output path except none.

## Structure
- pampy_pkg: opcode constants, state enum, ALU_OP encodings, PC_W default.
- Sub-module pampy_sp_tracker: SP register with push/pop-count update and overflow/underflow check, parameterised by STACK_DEPTH.

## Test plan
- Reset then LOAD_CONST 5, LOAD_CONST 3, BINARY_ADD, RETURN_VALUE, zero-wait -> 3 cycles each, ALU_OP=0 with POP_CNT=2/PUSH=1 once, SP 1,2,1,0, HALT_OUT=1, ERR_OUT=0, PC=6.
- MEM_ACK delayed 4 cycles on PC 0 -> MEM_REQ held 4 cycles, MEM_ADDR stable 0, single latch.
- POP_JUMP_IF_FALSE arg 0x20 with TOP_STACK_IN 0 -> PC 0x020; with 7 -> PC+2; SP decremented both cases.
- POP_TOP at SP=0 -> no strobes, ERR_OUT=1, HALT, PC unchanged; 17 LOAD_CONSTs at depth 16 -> 17th errors.
- Opcode 0xFF -> ERR_OUT=1, HALT; remains until reset.
- general_reset asserted mid-FETCH and mid-EXEC -> all outputs 0 same cycle, restart from PC 0 via IDLE.

Source files
------------

// File: rtl/pampy_pkg.sv
// Shared opcodes, FSM states and decode bundle for the pamPy sequencer.
package pampy_pkg;

  localparam int PC_W_DEF        = 12;
  localparam int STACK_DEPTH_DEF = 16;

  localparam logic [7:0] OP_POP_TOP = 8'h01;
  localparam logic [7:0] OP_NOP     = 8'h09;
  localparam logic [7:0] OP_ADD     = 8'h17;
  localparam logic [7:0] OP_SUB     = 8'h18;
  localparam logic [7:0] OP_RET     = 8'h53;
  localparam logic [7:0] OP_LOAD    = 8'h64;
  localparam logic [7:0] OP_JABS    = 8'h71;
  localparam logic [7:0] OP_JIF     = 8'h72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1
  } alu_op_e;

  typedef struct packed {
    logic       push;
    logic [1:0] pop_cnt;
    logic       src_alu;
    alu_op_e    alu_op;
    logic       jump;
    logic       cjump;
    logic       ret;
    logic       err;
  } dec_t;

  function automatic dec_t decode_op(input logic [7:0] op);
    dec_t d;
    d = '0;
    unique case (op)
      OP_NOP: ;
      OP_POP_TOP: d.pop_cnt = 2'd1;
      OP_ADD: begin
        d.pop_cnt = 2'd2;
        d.push    = 1'b1;
        d.src_alu = 1'b1;
        d.alu_op  = ALU_ADD;
      end
      OP_SUB: begin
        d.pop_cnt = 2'd2;
        d.push    = 1'b1;
        d.src_alu = 1'b1;
        d.alu_op  = ALU_SUB;
      end
      OP_LOAD: d.push = 1'b1;
      OP_JABS: d.jump = 1'b1;
      OP_JIF: begin
        d.pop_cnt = 2'd1;
        d.cjump   = 1'b1;
      end
      OP_RET: begin
        d.pop_cnt = 2'd1;
        d.ret     = 1'b1;
      end
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pampy_sp_tracker.sv
// Stack depth register with a combinational pre-check of the pending
// instruction's push/pop against the current depth.
module pampy_sp_tracker #(
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            chk_push_i,
  input  logic [1:0]      chk_pop_i,
  output logic            fault_o,
  input  logic            upd_i,
  input  logic            upd_push_i,
  input  logic [1:0]      upd_pop_i,
  output logic [SP_W-1:0] sp_o
);

  localparam logic [SP_W:0] DEPTH = (SP_W + 1)'(STACK_DEPTH);

  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W:0]   sp_x, after;
  logic            under, over;

  // One extra bit so the post-op depth can exceed STACK_DEPTH.
  always_comb begin
    sp_x    = {1'b0, sp_q};
    under   = sp_x < (SP_W + 1)'(chk_pop_i);
    after   = sp_x - (SP_W + 1)'(chk_pop_i)
            + (SP_W + 1)'(chk_push_i);
    over    = !under && (after > DEPTH);
    fault_o = under | over;
  end

  always_comb begin
    sp_d = sp_q;
    if (upd_i) begin
      sp_d = sp_q - SP_W'(upd_pop_i)
           + SP_W'(upd_push_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp_o = sp_q;

endmodule

// File: rtl/pampy_ctrl.sv
// pamPy instruction sequencer: fetch/decode/exec FSM, PC and strobes.
// Strobes are decoded from registered state only.
module pampy_ctrl
  import pampy_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int PC_W        = PC_W_DEF
) (
  input  logic                               general_clk,
  input  logic                               general_reset,
  output logic                               MEM_REQ,
  output logic [PC_W-1:0]                    MEM_ADDR,
  input  logic                               MEM_ACK,
  input  logic [7:0]                         MEM_INSTR_IN,
  input  logic [7:0]                         MEM_ARG_IN,
  input  logic [7:0]                         TOP_STACK_IN,
  output logic                               STACK_PUSH,
  output logic [1:0]                         STACK_POP_CNT,
  output logic                               STACK_SRC_SEL,
  output logic [1:0]                         ALU_OP,
  output logic [PC_W-1:0]                    GENERAL_PC_OUT,
  output logic [7:0]                         GENERAL_INSTR_OUT,
  output logic [7:0]                         GENERAL_ARG_OUT,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   SP_OUT,
  output logic                               HALT_OUT,
  output logic                               ERR_OUT
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, arg_q;
  dec_t            dec_q, dec_d, dec_now;
  logic            err_q, err_d;
  logic            sp_fault;
  logic            exec_ok;
  logic            take_jump;

  assign dec_now = decode_op(instr_q);
  assign exec_ok = (state_q == ST_EXEC) && !dec_q.err;

  pampy_sp_tracker #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_sp (
    .clk_i     (general_clk),
    .rst_i     (general_reset),
    .chk_push_i(dec_now.push),
    .chk_pop_i (dec_now.pop_cnt),
    .fault_o   (sp_fault),
    .upd_i     (exec_ok),
    .upd_push_i(dec_q.push),
    .upd_pop_i (dec_q.pop_cnt),
    .sp_o      (SP_OUT)
  );

  assign take_jump = dec_q.jump
                   || (dec_q.cjump && (TOP_STACK_IN == 8'd0));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    dec_d   = dec_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (MEM_ACK) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        dec_d     = dec_now;
        dec_d.err = dec_now.err | sp_fault;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        // A faulting instruction leaves the PC on itself.
        if (dec_q.err) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else if (dec_q.ret) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          if (take_jump) pc_d = PC_W'(arg_q);
          else           pc_d = pc_q + PC_W'(2);
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge general_clk or posedge general_reset) begin
    if (general_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      dec_q   <= dec_d;
    end
  end

  always_ff @(posedge general_clk or posedge general_reset) begin
    if (general_reset) begin
      instr_q <= '0;
      arg_q   <= '0;
    end else if ((state_q == ST_FETCH) && MEM_ACK) begin
      instr_q <= MEM_INSTR_IN;
      arg_q   <= MEM_ARG_IN;
    end
  end

  assign MEM_REQ           = (state_q == ST_FETCH);
  assign MEM_ADDR          = pc_q;
  assign STACK_PUSH        = exec_ok & dec_q.push;
  assign STACK_POP_CNT     = exec_ok ? dec_q.pop_cnt : 2'd0;
  assign STACK_SRC_SEL     = exec_ok & dec_q.src_alu;
  assign ALU_OP            = exec_ok ? dec_q.alu_op : 2'd0;
  assign GENERAL_PC_OUT    = pc_q;
  assign GENERAL_INSTR_OUT = instr_q;
  assign GENERAL_ARG_OUT   = arg_q;
  assign HALT_OUT          = (state_q == ST_HALT);
  assign ERR_OUT           = err_q;

endmodule

// File: tb/tb_pampy_ctrl.sv
// Directed bench for pampy_ctrl: program steps with hand-derived results.
module tb_pampy_ctrl;

  localparam int PC_W = 12;
  localparam int SD   = 16;
  localparam int SP_W = 5;

  localparam logic [7:0] LOAD = 8'h64, ADD = 8'h17, SUB = 8'h18;
  localparam logic [7:0] RET  = 8'h53, POPT = 8'h01, NOP = 8'h09;
  localparam logic [7:0] JABS = 8'h71, JIF = 8'h72;

  logic            clk = 1'b0;
  logic            rst;
  logic            MEM_REQ, MEM_ACK;
  logic [PC_W-1:0] MEM_ADDR, GENERAL_PC_OUT;
  logic [7:0]      MEM_INSTR_IN, MEM_ARG_IN, TOP_STACK_IN;
  logic            STACK_PUSH, STACK_SRC_SEL, HALT_OUT, ERR_OUT;
  logic [1:0]      STACK_POP_CNT, ALU_OP;
  logic [7:0]      GENERAL_INSTR_OUT, GENERAL_ARG_OUT;
  logic [SP_W-1:0] SP_OUT;

  always #5 clk = ~clk;

  pampy_ctrl #(.STACK_DEPTH(SD), .PC_W(PC_W)) dut (
    .general_clk      (clk),
    .general_reset    (rst),
    .MEM_REQ          (MEM_REQ),
    .MEM_ADDR         (MEM_ADDR),
    .MEM_ACK          (MEM_ACK),
    .MEM_INSTR_IN     (MEM_INSTR_IN),
    .MEM_ARG_IN       (MEM_ARG_IN),
    .TOP_STACK_IN     (TOP_STACK_IN),
    .STACK_PUSH       (STACK_PUSH),
    .STACK_POP_CNT    (STACK_POP_CNT),
    .STACK_SRC_SEL    (STACK_SRC_SEL),
    .ALU_OP           (ALU_OP),
    .GENERAL_PC_OUT   (GENERAL_PC_OUT),
    .GENERAL_INSTR_OUT(GENERAL_INSTR_OUT),
    .GENERAL_ARG_OUT  (GENERAL_ARG_OUT),
    .SP_OUT           (SP_OUT),
    .HALT_OUT         (HALT_OUT),
    .ERR_OUT          (ERR_OUT)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic            e_push, e_src;
  logic [1:0]      e_pop, e_alu;
  logic [PC_W-1:0] e_pc;
  int              t_req, t_prev, t_rel, req_cnt;
  logic            req_bad;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    MEM_ACK      = 1'b0;
    MEM_INSTR_IN = 8'h00;
    MEM_ARG_IN   = 8'h00;
    TOP_STACK_IN = 8'h00;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    t_rel = cyc;
  endtask

  // Serve one fetch with dly wait cycles, then observe DECODE/EXEC.
  task automatic step(input logic [7:0] op, input logic [7:0] arg,
                      input int dly, input logic [7:0] top,
                      input bit stop_in_exec);
    int n;
    logic [PC_W-1:0] a0;
    n = 0;
    while (!MEM_REQ && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!MEM_REQ) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout: MEM_REQ got 0 required 1");
    end
    t_prev  = t_req;
    t_req   = cyc;
    req_cnt = 0;
    req_bad = 1'b0;
    a0      = MEM_ADDR;
    for (int i = 0; i < dly; i++) begin
      req_cnt++;
      if (!MEM_REQ || MEM_ADDR !== a0) req_bad = 1'b1;
      @(negedge clk);
    end
    if (!MEM_REQ || MEM_ADDR !== a0) req_bad = 1'b1;
    req_cnt++;
    MEM_ACK      = 1'b1;
    MEM_INSTR_IN = op;
    MEM_ARG_IN   = arg;
    @(negedge clk);
    // Stray ACK during DECODE must not re-latch.
    MEM_INSTR_IN = 8'hEE;
    MEM_ARG_IN   = 8'hEE;
    TOP_STACK_IN = top;
    @(negedge clk);
    MEM_ACK = 1'b0;
    e_push  = STACK_PUSH;
    e_pop   = STACK_POP_CNT;
    e_src   = STACK_SRC_SEL;
    e_alu   = ALU_OP;
    e_pc    = GENERAL_PC_OUT;
    if (!stop_in_exec) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    t_req = 0;
    do_reset();
    chk("rst_req",   32'(MEM_REQ), 0);
    chk("rst_pc",    32'(GENERAL_PC_OUT), 0);
    chk("rst_sp",    32'(SP_OUT), 0);
    chk("rst_instr", 32'(GENERAL_INSTR_OUT), 0);
    chk("rst_halt",  32'(HALT_OUT), 0);
    chk("rst_err",   32'(ERR_OUT), 0);
    chk("rst_push",  32'(STACK_PUSH), 0);

    // 5 + 3 then return
    step(LOAD, 8'd5, 0, 8'd0, 0);
    chk("idle_1cyc", 32'(t_req - t_rel), 1);
    chk("ld1_push",  32'(e_push), 1);
    chk("ld1_src",   32'(e_src), 0);
    chk("ld1_sp",    32'(SP_OUT), 1);
    step(LOAD, 8'd3, 0, 8'd0, 0);
    chk("ld2_lat",   32'(t_req - t_prev), 3);
    chk("ld2_sp",    32'(SP_OUT), 2);
    step(ADD, 8'd0, 0, 8'd0, 0);
    chk("add_push",  32'(e_push), 1);
    chk("add_pop",   32'(e_pop), 2);
    chk("add_src",   32'(e_src), 1);
    chk("add_alu",   32'(e_alu), 0);
    chk("add_sp",    32'(SP_OUT), 1);
    step(RET, 8'd0, 0, 8'd0, 0);
    chk("ret_pop",   32'(e_pop), 1);
    chk("ret_push",  32'(e_push), 0);
    chk("ret_sp",    32'(SP_OUT), 0);
    chk("ret_halt",  32'(HALT_OUT), 1);
    chk("ret_err",   32'(ERR_OUT), 0);
    chk("ret_pc",    32'(GENERAL_PC_OUT), 6);

    // wait states, subtract, jumps, underflow
    do_reset();
    step(LOAD, 8'd9, 3, 8'd0, 0);
    chk("wait_req_cnt", 32'(req_cnt), 4);
    chk("wait_addr",    32'(req_bad), 0);
    chk("wait_instr",   32'(GENERAL_INSTR_OUT), 32'h64);
    chk("wait_arg",     32'(GENERAL_ARG_OUT), 9);
    step(LOAD, 8'd4, 0, 8'd0, 0);
    step(SUB, 8'd0, 0, 8'd0, 0);
    chk("sub_alu", 32'(e_alu), 1);
    chk("sub_sp",  32'(SP_OUT), 1);
    step(JIF, 8'h20, 0, 8'd0, 0);
    chk("jif0_pop", 32'(e_pop), 1);
    chk("jif0_pc",  32'(GENERAL_PC_OUT), 32'h020);
    chk("jif0_sp",  32'(SP_OUT), 0);
    step(LOAD, 8'd1, 0, 8'd0, 0);
    chk("tgt_pc", 32'(e_pc), 32'h020);
    step(JIF, 8'h40, 0, 8'd7, 0);
    chk("jif7_pc", 32'(GENERAL_PC_OUT), 32'h024);
    chk("jif7_sp", 32'(SP_OUT), 0);
    step(JABS, 8'h10, 0, 8'd0, 0);
    chk("jabs_pc",  32'(GENERAL_PC_OUT), 32'h010);
    chk("jabs_pop", 32'(e_pop), 0);
    step(NOP, 8'd0, 0, 8'd0, 0);
    chk("nop_pc", 32'(GENERAL_PC_OUT), 32'h012);
    step(POPT, 8'd0, 0, 8'd0, 0);
    chk("uf_pop",  32'(e_pop), 0);
    chk("uf_err",  32'(ERR_OUT), 1);
    chk("uf_halt", 32'(HALT_OUT), 1);
    chk("uf_pc",   32'(GENERAL_PC_OUT), 32'h012);
    repeat (5) @(negedge clk);
    chk("uf_stay_halt", 32'(HALT_OUT), 1);
    chk("uf_stay_req",  32'(MEM_REQ), 0);

    // overflow on the 17th push
    do_reset();
    for (int i = 0; i < SD; i++) step(LOAD, 8'(i), 0, 8'd0, 0);
    chk("full_sp", 32'(SP_OUT), 16);
    step(LOAD, 8'd99, 0, 8'd0, 0);
    chk("of_push", 32'(e_push), 0);
    chk("of_err",  32'(ERR_OUT), 1);
    chk("of_halt", 32'(HALT_OUT), 1);
    chk("of_pc",   32'(GENERAL_PC_OUT), 32);
    chk("of_sp",   32'(SP_OUT), 16);

    // illegal opcode
    do_reset();
    step(8'hFF, 8'd0, 0, 8'd0, 0);
    chk("ill_push", 32'(e_push), 0);
    chk("ill_err",  32'(ERR_OUT), 1);
    chk("ill_halt", 32'(HALT_OUT), 1);
    chk("ill_pc",   32'(GENERAL_PC_OUT), 0);

    // reset mid-FETCH with an ACK pending
    do_reset();
    step(LOAD, 8'd2, 0, 8'd0, 0);
    while (!MEM_REQ) @(negedge clk);
    MEM_ACK      = 1'b1;
    MEM_INSTR_IN = 8'h64;
    #2 rst = 1'b1;
    #1;
    chk("rf_req", 32'(MEM_REQ), 0);
    chk("rf_pc",  32'(GENERAL_PC_OUT), 0);
    chk("rf_sp",  32'(SP_OUT), 0);
    @(negedge clk);
    MEM_ACK = 1'b0;
    rst     = 1'b0;
    t_rel   = cyc;
    chk("rf_instr", 32'(GENERAL_INSTR_OUT), 0);
    step(LOAD, 8'd7, 0, 8'd0, 0);
    chk("rf_restart", 32'(t_req - t_rel), 1);
    chk("rf_pc0",     32'(e_pc), 0);

    // reset mid-EXEC
    step(LOAD, 8'd8, 0, 8'd0, 1);
    chk("re_push_pre", 32'(e_push), 1);
    #1 rst = 1'b1;
    #1;
    chk("re_push",  32'(STACK_PUSH), 0);
    chk("re_sp",    32'(SP_OUT), 0);
    chk("re_pc",    32'(GENERAL_PC_OUT), 0);
    chk("re_instr", 32'(GENERAL_INSTR_OUT), 0);
    @(negedge clk);
    rst   = 1'b0;
    t_rel = cyc;
    step(LOAD, 8'd1, 0, 8'd0, 0);
    chk("re_restart", 32'(t_req - t_rel), 1);
    chk("re_pc0",     32'(e_pc), 0);
    chk("re_sp1",     32'(SP_OUT), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
